easyaxi_rd_arb: RTL

//  Shares one downstream AXI read port (AR+R) among NUM_REQ upstream read masters.

---
 rtl/easyaxi_rd_arb_pkg.sv | 37 +++
 rtl/easyaxi_rr_arb.sv | 38 +++
 rtl/easyaxi_rd_arb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/easyaxi_rd_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | easyaxi_rd_arb_pkg                                                       |
// | Shared AXI widths, encodings and arbiter FSM type for easyaxi_rd_arb.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package easyaxi_rd_arb_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_DECERR = 2'b11;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Index width with a floor of one bit so a lone requester still has a field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : easyaxi_rd_arb_pkg
`default_nettype wire

// File: rtl/easyaxi_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | easyaxi_rr_arb                                                           |
// | Combinational round-robin picker: first request at or after rr_ptr.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module easyaxi_rr_arb #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    always_comb begin : p_pick
        int k;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        k         = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!any_grant && req[k]) begin
                any_grant = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

endmodule : easyaxi_rr_arb
`default_nettype wire

// File: rtl/easyaxi_rd_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | easyaxi_rd_arb                                                           |
// | Round-robin AR arbiter with ID-tagged R routing and per-requester        |
// | outstanding limits. Define EASYAXI_RD_ARB_PERF_EN for grant counters.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module easyaxi_rd_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MAX_OST = 8,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                s_arvalid,
    output logic [NUM_REQ-1:0]                s_arready,
    input  logic [NUM_REQ*AXI_ID_W-1:0]       s_arid,
    input  logic [NUM_REQ*AXI_ADDR_W-1:0]     s_araddr,
    input  logic [NUM_REQ*AXI_LEN_W-1:0]      s_arlen,
    input  logic [NUM_REQ*AXI_SIZE_W-1:0]     s_arsize,
    input  logic [NUM_REQ*AXI_BURST_W-1:0]    s_arburst,
    output logic [NUM_REQ-1:0]                s_rvalid,
    input  logic [NUM_REQ-1:0]                s_rready,
    output logic [AXI_ID_W-1:0]               s_rid,
    output logic [AXI_DATA_W-1:0]             s_rdata,
    output logic [AXI_RESP_W-1:0]             s_rresp,
    output logic                              s_rlast,
    output logic                              m_arvalid,
    input  logic                              m_arready,
    output logic [AXI_ID_W+IDX_W-1:0]         m_arid,
    output logic [AXI_ADDR_W-1:0]             m_araddr,
    output logic [AXI_LEN_W-1:0]              m_arlen,
    output logic [AXI_SIZE_W-1:0]             m_arsize,
    output logic [AXI_BURST_W-1:0]            m_arburst,
    input  logic                              m_rvalid,
    input  logic [AXI_ID_W+IDX_W-1:0]         m_rid,
    input  logic [AXI_DATA_W-1:0]             m_rdata,
    input  logic [AXI_RESP_W-1:0]             m_rresp,
    input  logic                              m_rlast,
    output logic                              m_rready,
    output logic                              route_err,
    output logic [NUM_REQ*16-1:0]             perf_grant_cnt
);

    localparam int OST_W = $clog2(MAX_OST) + 1;
    localparam logic [OST_W-1:0] c_OST_FULL = OST_W'(MAX_OST);

    arb_state_e                          r_state, w_state_nxt;
    logic [IDX_W-1:0]                    r_grant_idx, w_grant_idx_nxt;
    logic [NUM_REQ-1:0]                  r_grant_oh, w_grant_oh_nxt;
    logic [IDX_W-1:0]                    r_rr_ptr, w_rr_ptr_nxt;
    logic [NUM_REQ-1:0][OST_W-1:0]       r_ost_cnt;
    logic                                r_route_err;

    logic [NUM_REQ-1:0]                  w_eligible;
    logic [NUM_REQ-1:0]                  w_pick_oh;
    logic [IDX_W-1:0]                    w_pick_idx;
    logic                                w_pick_any;
    logic                                w_busy;
    logic                                w_ar_hs;
    logic [NUM_REQ-1:0]                  w_ar_inc;
    logic [IDX_W-1:0]                    w_r_idx;
    logic [NUM_REQ-1:0]                  w_r_sel;
    logic                                w_r_ok;
    logic                                w_r_hs;
    logic [NUM_REQ-1:0]                  w_r_dec;
    logic [NUM_REQ-1:0]                  w_dec_err;

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_elig
            assign w_eligible[k] = s_arvalid[k] & (r_ost_cnt[k] != c_OST_FULL);
            assign w_r_sel[k]    = (w_r_idx == IDX_W'(k));
        end
    endgenerate

    easyaxi_rr_arb #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req       (w_eligible),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_pick_oh),
        .grant_idx (w_pick_idx),
        .any_grant (w_pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_grant_oh  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_grant_oh  <= w_grant_oh_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    // The grant is held in BUSY until the downstream handshake; no preemption.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_idx_nxt = r_grant_idx;
        w_grant_oh_nxt  = r_grant_oh;
        w_rr_ptr_nxt    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt     = ST_BUSY;
                    w_grant_idx_nxt = w_pick_idx;
                    w_grant_oh_nxt  = w_pick_oh;
                end
            end
            ST_BUSY: begin
                if (m_arready) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                 : r_grant_idx + IDX_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_busy    = (r_state == ST_BUSY);
    assign w_ar_hs   = w_busy & m_arready;
    assign w_ar_inc  = w_ar_hs ? r_grant_oh : '0;
    assign m_arvalid = w_busy;
    assign s_arready = w_ar_inc;

    assign m_arid    = w_busy ? {r_grant_idx, s_arid[int'(r_grant_idx)*AXI_ID_W +: AXI_ID_W]} : '0;
    assign m_araddr  = w_busy ? s_araddr[int'(r_grant_idx)*AXI_ADDR_W +: AXI_ADDR_W] : '0;
    assign m_arlen   = w_busy ? s_arlen[int'(r_grant_idx)*AXI_LEN_W +: AXI_LEN_W] : '0;
    assign m_arsize  = w_busy ? s_arsize[int'(r_grant_idx)*AXI_SIZE_W +: AXI_SIZE_W] : '0;
    assign m_arburst = w_busy ? s_arburst[int'(r_grant_idx)*AXI_BURST_W +: AXI_BURST_W] : '0;

    // Beats whose index names no requester are swallowed so the slave never stalls.
    assign w_r_idx  = m_rid[AXI_ID_W +: IDX_W];
    assign w_r_ok   = |w_r_sel;
    assign m_rready = w_r_ok ? |(w_r_sel & s_rready) : 1'b1;
    assign s_rvalid = m_rvalid ? w_r_sel : '0;
    assign w_r_hs   = m_rvalid & m_rready;
    assign w_r_dec  = (w_r_hs & m_rlast) ? w_r_sel : '0;

    assign s_rid   = m_rid[AXI_ID_W-1:0];
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

    assign w_dec_err = w_r_dec & ~w_ar_inc & {NUM_REQ{1'b0}} | w_r_dec & ~w_ar_inc & w_zero_cnt();

    function automatic logic [NUM_REQ-1:0] w_zero_cnt();
        logic [NUM_REQ-1:0] z;
        for (int k = 0; k < NUM_REQ; k++) begin
            z[k] = (r_ost_cnt[k] == '0);
        end
        return z;
    endfunction

    // A simultaneous grant and last beat for one requester cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ost_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_ar_inc[k] && !w_r_dec[k]) begin
                    r_ost_cnt[k] <= r_ost_cnt[k] + OST_W'(1);
                end else if (w_r_dec[k] && !w_ar_inc[k] && (r_ost_cnt[k] != '0)) begin
                    r_ost_cnt[k] <= r_ost_cnt[k] - OST_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_route_err <= 1'b0;
        end else if ((w_r_hs && !w_r_ok) || (|w_dec_err)) begin
            r_route_err <= 1'b1;
        end
    end

    assign route_err = r_route_err;

`ifdef EASYAXI_RD_ARB_PERF_EN
    logic [NUM_REQ-1:0][15:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_ar_inc[k] && (r_perf_cnt[k] != 16'hFFFF)) begin
                    r_perf_cnt[k] <= r_perf_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign perf_grant_cnt = r_perf_cnt;
`else
    assign perf_grant_cnt = '0;
`endif

endmodule : easyaxi_rd_arb
`default_nettype wire
